contador_updown_param: RTL and testbench
========================================

Name: contador_updown_param

Overview:
- Parametrised up/down counter; next generation of the team's 8-bit up/down counter.
- Adds: configurable width and range, variable step, synchronous load, count enable, wrap or saturate mode, boundary flags and one-cycle overflow/underflow pulses.
- Used as a general event/position counter in the L-series datapaths; all outputs are registered.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- RESET_VALUE, 8'h6A (106), value of saida after reset; must satisfy MIN_VALUE <= RESET_VALUE <= MAX_VALUE.
- MIN_VALUE, 0, lower bound of the count range (unsigned).
- MAX_VALUE, 2**WIDTH-1, upper bound of the count range; must satisfy MIN_VALUE < MAX_VALUE.
- STEP_W, 4, width of the step input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates acrescer/decrecer only.
- acrescer  in  1  count up by step.
- decrecer  in  1  count down by step.
- step  in  STEP_W  step magnitude, unsigned; the integrator guarantees step <= MAX_VALUE-MIN_VALUE+1.
- modo  in  1  0 = wrap, 1 = saturate; sampled every cycle.
- load  in  1  synchronous load request.
- load_value  in  WIDTH  value to load.
- saida  out  WIDTH  current count.
- no_max  out  1  high when saida == MAX_VALUE.
- no_min  out  1  high when saida == MIN_VALUE.
- overflow  out  1  one-cycle pulse: an up-count crossed MAX_VALUE (wrapped or clamped).
- underflow  out  1  one-cycle pulse: a down-count crossed MIN_VALUE (wrapped or clamped).

Behaviour:
- Reset (asserted at any time, including mid-count or mid-load): saida = RESET_VALUE, overflow = underflow = 0, and no_max/no_min are consistent with RESET_VALUE. Reset takes effect immediately, without waiting for clk.
- Priority per edge: rst > load > count > hold.
- Load: saida <= clamp(load_value, MIN_VALUE, MAX_VALUE). Load ignores en, acrescer and decrecer. overflow/underflow stay 0, including when clamping occurs.
- Count happens only when en = 1 and exactly one of acrescer/decrecer is high:
  - acrescer = 1 and decrecer = 1 together: hold, no pulses.
  - step = 0: hold, no pulses.
- Arithmetic is computed in WIDTH+1 bits, so the intermediate sum never truncates.
- Up-count, sum = saida + step:
  - sum <= MAX_VALUE: saida <= sum.
  - sum > MAX_VALUE, wrap mode: saida <= MIN_VALUE + (sum - MAX_VALUE - 1); overflow = 1.
  - sum > MAX_VALUE, saturate mode: saida <= MAX_VALUE; overflow = 1. This includes the case where saida is already MAX_VALUE.
- Down-count, diff = saida - step:
  - diff >= MIN_VALUE (no borrow below MIN_VALUE): saida <= diff.
  - Otherwise, wrap mode: saida <= MAX_VALUE - (MIN_VALUE - diff - 1); underflow = 1.
  - Otherwise, saturate mode: saida <= MIN_VALUE; underflow = 1.
- Pulse timing: overflow/underflow are registered and high for exactly the cycle after the edge that caused the crossing. They are low in every other cycle. They are never both high.
- Flags: no_max and no_min are registered alongside saida, so they reflect the new saida in the same cycle with no extra latency.
- Latency: one clk from an input change to the saida update.
- Range: saida never leaves [MIN_VALUE, MAX_VALUE].
- Mode switching: a change on modo applies from the edge at which it is sampled; no internal mode state exists.

Test Plan:
1. Default parameters: assert rst asynchronously between edges -> saida = 0x6A immediately, pulses 0. Release rst, acrescer = 1, en = 1, step = 1 for 3 edges -> saida = 0x6D.
2. Wrap up, MIN = 10, MAX = 20, saida = 19, step = 3, modo = 0 -> saida = 11, overflow high for one cycle, no_max = 0.
3. Saturate down, MIN = 10, MAX = 20, saida = 12, step = 5, modo = 1 -> saida = 10, underflow = 1, no_min = 1. Next edge, same inputs -> saida = 10, underflow = 1 again.
4. Simultaneous inputs: acrescer = decrecer = 1, en = 1 -> saida holds, no pulses. en = 0 with acrescer = 1 -> hold.
5. Load priority: load = 1, load_value = 0x30, acrescer = 1 -> saida = 0x30. MIN = 10, MAX = 20, load_value = 99 -> saida = 20, overflow = 0.
6. Reset mid-operation: assert rst during a saturating up-count at MAX -> saida = RESET_VALUE, overflow = 0 on the following cycle. Counting resumes correctly after release.

Source files
------------

// File: rtl/contador_updown_param.sv
// ============================================================================
// Module   : contador_updown_param
// Brief    : Parametrised up/down counter with step, load, wrap/saturate mode,
//            boundary flags and one-cycle overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_updown_param #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = 8'h6A,
    parameter logic [WIDTH-1:0]      MIN_VALUE   = '0,
    parameter logic [WIDTH-1:0]      MAX_VALUE   = {WIDTH{1'b1}},
    parameter int unsigned           STEP_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              acrescer,
    input  logic              decrecer,
    input  logic [STEP_W-1:0] step,
    input  logic              modo,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  saida,
    output logic              no_max,
    output logic              no_min,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned AW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

    localparam logic [WIDTH-1:0] c_one       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   c_range_ext = {1'b0, MAX_VALUE - MIN_VALUE};
    localparam logic             c_rst_max   = (RESET_VALUE == MAX_VALUE);
    localparam logic             c_rst_min   = (RESET_VALUE == MIN_VALUE);

    logic [WIDTH-1:0] saida_q,     saida_d;
    logic             no_max_q,    no_max_d;
    logic             no_min_q,    no_min_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW-1:0]    step_aw;
    logic [AW-1:0]    dist_up_aw;
    logic [AW-1:0]    dist_dn_aw;
    logic [WIDTH-1:0] dist_up;
    logic [WIDTH-1:0] dist_dn;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   lv_off;
    logic             count_ok;
    logic             up_cross;
    logic             dn_cross;

    // Step is widened so the crossing compare never truncates either operand.
    generate
        if (STEP_W < AW) begin : g_step_pad
            assign step_aw = {{(AW-STEP_W){1'b0}}, step};
        end else begin : g_step_full
            assign step_aw = step;
        end
    endgenerate

    assign dist_up    = MAX_VALUE - saida_q;
    assign dist_dn    = saida_q - MIN_VALUE;
    assign dist_up_aw = {{(AW-WIDTH){1'b0}}, dist_up};
    assign dist_dn_aw = {{(AW-WIDTH){1'b0}}, dist_dn};
    assign step_lo    = step_aw[WIDTH-1:0];

    // A crossing occurs when the step exceeds the headroom toward the bound.
    assign up_cross = (step_aw > dist_up_aw);
    assign dn_cross = (step_aw > dist_dn_aw);
    assign count_ok = en && (acrescer ^ decrecer) && (step != '0);

    // MSB is the borrow below MIN_VALUE; the full value exceeds the range above MAX_VALUE.
    assign lv_off = {1'b0, load_value} - {1'b0, MIN_VALUE};

    always_comb begin
        saida_d     = saida_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (load) begin
            if (lv_off[WIDTH]) begin
                saida_d = MIN_VALUE;
            end else if (lv_off > c_range_ext) begin
                saida_d = MAX_VALUE;
            end else begin
                saida_d = load_value;
            end
        end else if (count_ok) begin
            if (acrescer) begin
                if (up_cross) begin
                    overflow_d = 1'b1;
                    // Excess past MAX is at most the range, so WIDTH-bit arithmetic is exact.
                    saida_d    = modo ? MAX_VALUE
                                      : MIN_VALUE + (step_lo - dist_up - c_one);
                end else begin
                    saida_d = saida_q + step_lo;
                end
            end else begin
                if (dn_cross) begin
                    underflow_d = 1'b1;
                    saida_d     = modo ? MIN_VALUE
                                       : MAX_VALUE - (step_lo - dist_dn - c_one);
                end else begin
                    saida_d = saida_q - step_lo;
                end
            end
        end

        no_max_d = (saida_d == MAX_VALUE);
        no_min_d = (saida_d == MIN_VALUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saida_q     <= RESET_VALUE;
            no_max_q    <= c_rst_max;
            no_min_q    <= c_rst_min;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            saida_q     <= saida_d;
            no_max_q    <= no_max_d;
            no_min_q    <= no_min_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign saida     = saida_q;
    assign no_max    = no_max_q;
    assign no_min    = no_min_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_updown_param.sv
// ============================================================================
// Module   : tb_contador_updown_param
// Brief    : Bench for contador_updown_param; a full-range and a 10..20 instance
//            share stimulus and are checked against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_updown_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       acrescer;
    logic       decrecer;
    logic [3:0] step;
    logic       modo;
    logic       load;
    logic [7:0] load_value;

    logic [7:0] saida0, saida1;
    logic       no_max0, no_max1, no_min0, no_min1;
    logic       ov0, ov1, un0, un1;

    int checks = 0;
    int errors = 0;

    int m_saida [2];
    int m_ov    [2];
    int m_un    [2];
    int c_min   [2] = '{0, 10};
    int c_max   [2] = '{255, 20};
    int c_rst   [2] = '{106, 15};

    contador_updown_param u_dut_full (
        .clk(clk), .rst(rst), .en(en), .acrescer(acrescer), .decrecer(decrecer),
        .step(step), .modo(modo), .load(load), .load_value(load_value),
        .saida(saida0), .no_max(no_max0), .no_min(no_min0),
        .overflow(ov0), .underflow(un0)
    );

    contador_updown_param #(
        .WIDTH(8), .RESET_VALUE(8'd15), .MIN_VALUE(8'd10), .MAX_VALUE(8'd20), .STEP_W(4)
    ) u_dut_rng (
        .clk(clk), .rst(rst), .en(en), .acrescer(acrescer), .decrecer(decrecer),
        .step(step), .modo(modo), .load(load), .load_value(load_value),
        .saida(saida1), .no_max(no_max1), .no_min(no_min1),
        .overflow(ov1), .underflow(un1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_saida[i] = c_rst[i];
            m_ov[i]    = 0;
            m_un[i]    = 0;
        end
    endtask

    // Next state from the rules: reset > load (clamp) > count > hold.
    task automatic model_edge();
        int s;
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0;
            m_un[i] = 0;
            if (rst) begin
                m_saida[i] = c_rst[i];
            end else if (load) begin
                s = int'(load_value);
                m_saida[i] = (s < c_min[i]) ? c_min[i] : (s > c_max[i]) ? c_max[i] : s;
            end else if (en && (acrescer != decrecer) && step != 0) begin
                if (acrescer) begin
                    s = m_saida[i] + int'(step);
                    if (s > c_max[i]) begin
                        m_ov[i]    = 1;
                        m_saida[i] = modo ? c_max[i] : c_min[i] + (s - c_max[i] - 1);
                    end else begin
                        m_saida[i] = s;
                    end
                end else begin
                    s = m_saida[i] - int'(step);
                    if (s < c_min[i]) begin
                        m_un[i]    = 1;
                        m_saida[i] = modo ? c_min[i] : c_max[i] - (c_min[i] - s - 1);
                    end else begin
                        m_saida[i] = s;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_saida0"},  32'(saida0),  32'(m_saida[0]));
        chk({tag, "_nomax0"},  32'(no_max0), 32'(m_saida[0] == c_max[0]));
        chk({tag, "_nomin0"},  32'(no_min0), 32'(m_saida[0] == c_min[0]));
        chk({tag, "_ov0"},     32'(ov0),     32'(m_ov[0]));
        chk({tag, "_un0"},     32'(un0),     32'(m_un[0]));
        chk({tag, "_saida1"},  32'(saida1),  32'(m_saida[1]));
        chk({tag, "_nomax1"},  32'(no_max1), 32'(m_saida[1] == c_max[1]));
        chk({tag, "_nomin1"},  32'(no_min1), 32'(m_saida[1] == c_min[1]));
        chk({tag, "_ov1"},     32'(ov1),     32'(m_ov[1]));
        chk({tag, "_un1"},     32'(un1),     32'(m_un[1]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic i_en, input logic i_up, input logic i_dn,
                          input logic [3:0] i_step, input logic i_modo,
                          input logic i_load, input logic [7:0] i_lv);
        en = i_en; acrescer = i_up; decrecer = i_dn; step = i_step;
        modo = i_modo; load = i_load; load_value = i_lv;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);

        // 1: asynchronous reset between edges, then three up-counts by 1
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t1_async_rst");
        chk("t1_rst_value", 32'(saida0), 32'h6A);
        cycle("t1_rst_held");
        rst = 1'b0;
        set_in(1, 1, 0, 1, 0, 0, 0);
        repeat (3) cycle("t1_up");
        chk("t1_saida_6d", 32'(saida0), 32'h6D);

        // 2: wrap up in 10..20
        set_in(0, 0, 0, 0, 0, 1, 8'd19);
        cycle("t2_load");
        set_in(1, 1, 0, 3, 0, 0, 0);
        cycle("t2_wrap");
        chk("t2_saida_11", 32'(saida1), 32'd11);
        chk("t2_ov_pulse", 32'(ov1), 32'd1);
        set_in(0, 1, 0, 3, 0, 0, 0);
        cycle("t2_after");
        chk("t2_ov_cleared", 32'(ov1), 32'd0);

        // 3: saturate down in 10..20, twice
        set_in(0, 0, 0, 0, 0, 1, 8'd12);
        cycle("t3_load");
        set_in(1, 0, 1, 5, 1, 0, 0);
        cycle("t3_sat1");
        chk("t3_saida_10", 32'(saida1), 32'd10);
        chk("t3_un_pulse", 32'(un1), 32'd1);
        cycle("t3_sat2");
        chk("t3_un_again", 32'(un1), 32'd1);

        // 4: simultaneous up/down, then enable low
        set_in(1, 1, 1, 4, 0, 0, 0);
        cycle("t4_both");
        set_in(0, 1, 0, 4, 0, 0, 0);
        cycle("t4_en_low");
        chk("t4_hold", 32'(saida1), 32'd10);

        // 5: load priority over counting and clamp without pulses
        set_in(1, 1, 0, 2, 0, 1, 8'h30);
        cycle("t5_load30");
        chk("t5_saida_30", 32'(saida0), 32'h30);
        set_in(1, 1, 0, 2, 0, 1, 8'd99);
        cycle("t5_load99");
        chk("t5_clamp_20", 32'(saida1), 32'd20);
        chk("t5_no_ov", 32'(ov1), 32'd0);
        set_in(0, 0, 0, 0, 0, 1, 8'd3);
        cycle("t5_clamp_low");

        // 6: reset during saturating up-count at MAX
        set_in(0, 0, 0, 0, 0, 1, 8'hFF);
        cycle("t6_load_max");
        set_in(1, 1, 0, 1, 1, 0, 0);
        cycle("t6_sat_max");
        chk("t6_ov_at_max", 32'(ov1), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        cycle("t6_rst_held");
        rst = 1'b0;
        cycle("t6_resume");
        chk("t6_resume_16", 32'(saida1), 32'd16);

        // Randomised traffic; step kept within the 10..20 instance's legal range
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                   4'($urandom_range(0, 11)), 1'($urandom),
                   ($urandom_range(0, 7) == 0), 8'($urandom));
            rst = ($urandom_range(0, 63) == 0);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
